// File: rtl/serial_adder_pkg.sv
// Shared types and limits for the bit-serial adder/subtractor.
// Optional signed-overflow output is enabled with SERIAL_ADDER_OVF_EN.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sa_state_t;

    localparam int MAX_WIDTH = 64;

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit full-adder cell used as the bit-slice of the serial adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ c;
    assign cout = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell, LSB first, WIDTH cycles per result.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    sa_state_t        state_r;
    sa_state_t        state_s;
    logic             accept_s;
    logic             last_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] sum_r;
    logic             carry_r;
    logic             cout_r;
    logic [CNT_W-1:0] cnt_r;
    logic             ready_r;
    logic             busy_r;
    logic             done_r;
    logic             fa_sum_s;
    logic             fa_cout_s;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_r;
`endif

    full_adder u_fa (
        .a    (a_r[0]),
        .b    (b_r[0]),
        .c    (carry_r),
        .sum  (fa_sum_s),
        .cout (fa_cout_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode; DONE accepts start like IDLE for back-to-back operation
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        last_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    accept_s = 1'b1;
                    state_s  = RUN;
                end else begin
                    state_s  = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == LAST_CNT) begin
                    last_s  = 1'b1;
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                if (start) begin
                    accept_s = 1'b1;
                    state_s  = RUN;
                end else begin
                    state_s  = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Handshake outputs registered from the next state so they align with state_r
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            ready_r <= (state_s != RUN);
            busy_r  <= (state_s == RUN);
            done_r  <= (state_s == DONE);
        end
    end

    // Operand shifters, carry, bit counter and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            carry_r <= 1'b0;
            cout_r  <= 1'b0;
            cnt_r   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_r   <= 1'b0;
`endif
        end else if (accept_s) begin
            a_r     <= a;
            b_r     <= sub ? ~b : b;
            sum_r   <= '0;
            carry_r <= sub;
            cout_r  <= 1'b0;
            cnt_r   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_r   <= 1'b0;
`endif
        end else if (state_r == RUN) begin
            a_r     <= a_r >> 1;
            b_r     <= b_r >> 1;
            sum_r   <= {fa_sum_s, sum_r[WIDTH-1:1]};
            carry_r <= fa_cout_s;
            // counter parks at zero after the MSB so it never wraps
            cnt_r   <= last_s ? '0 : cnt_r + CNT_W'(1);
            if (last_s) begin
                cout_r <= fa_cout_s;
`ifdef SERIAL_ADDER_OVF_EN
                ovf_r  <= carry_r ^ fa_cout_s;
`endif
            end
        end
    end

    assign ready = ready_r;
    assign busy  = busy_r;
    assign done  = done_r;
    assign sum   = sum_r;
    assign cout  = cout_r;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf   = ovf_r;
`endif

endmodule
